load_store_unit: RTL

- Sits between the execute stage and DataMemory, and is the only master of DataMemory's port.
- Accepts one load or store request at a time, in RISC-V funct3 encoding, on a byte address.
- Turns each request into one or more word accesses on DataMemory. DataMemory is word-indexed, with a combinational read and a synchronous write.
- Handles byte, halfword and word sizes, sign/zero extension, read-modify-write for sub-word stores, and misaligned accesses that span two words.

---
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a
// word-indexed DataMemory (combinational read, synchronous write).
// Sub-word and misaligned accesses are split into word accesses; sub-word
// and spanning stores use read-modify-write on each touched word.
//
// Handshake rules (both channels): a transfer happens at a rising CLK edge
// where valid and ready are both 1. req_ready is 1 only in IDLE, so at most
// one request is in flight. resp_valid stays high with stable resp_rdata and
// resp_err until the edge where resp_ready is 1.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD0     = 3'd1,
    S_LD1     = 3'd2,
    S_RMW_RD0 = 3'd3,
    S_WR0     = 3'd4,
    S_RMW_RD1 = 3'd5,
    S_WR1     = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_we;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_word0;
  logic [1:0]          r_off;
  logic [31:0]         r_wdata;
  logic                r_err;
  logic [31:0]         r_buf0;
  logic [31:0]         r_buf1;

  logic                w_req_legal;
  logic                w_req_sw_aligned;
  logic [ADDR_W-1:0]   w_word1;
  logic                w_span;
  logic [3:0]          w_size_mask;
  logic [7:0]          w_mask8;
  logic [63:0]         w_sdata64;
  logic [63:0]         w_ld64;
  logic [31:0]         w_ld_raw;
  logic [31:0]         w_ld_ext;
  logic                w_unused;

  // Address bits above the memory's word index are deliberately ignored.
  assign w_unused = ^req_addr[31:ADDR_W+2];

  // Legal loads: LB LH LW LBU LHU; legal stores: SB SH SW.
  assign w_req_legal = req_we ? (!req_funct3[2] && !(req_funct3[1] && req_funct3[0]))
                              : (!(req_funct3[1] && req_funct3[0]) && !(req_funct3[2] && req_funct3[1]));

  // A full aligned word store needs no read of the old word.
  assign w_req_sw_aligned = req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);

  // Second word wraps around the top of memory.
  assign w_word1 = r_word0 + 1'b1;

  // Spanning: halfword at offset 3, or any misaligned word.
  assign w_span = ((r_funct3[1:0] == 2'b01) && (r_off == 2'd3)) ||
                  ((r_funct3[1:0] == 2'b10) && (r_off != 2'd0));

  assign w_size_mask = (r_funct3[1:0] == 2'b00) ? 4'b0001 :
                       (r_funct3[1:0] == 2'b01) ? 4'b0011 :
                       (r_funct3[1:0] == 2'b10) ? 4'b1111 : 4'b0000;

  // Byte-lane enables and store data across the two-word window
  // (low half = word0, high half = word1).
  assign w_mask8   = {4'b0000, w_size_mask} << r_off;
  assign w_sdata64 = {32'h0, r_wdata} << {r_off, 3'b000};

  // Load bytes start at buf0 lane `offset` and continue into buf1.
  assign w_ld64   = {r_buf1, r_buf0} >> {r_off, 3'b000};
  assign w_ld_raw = w_ld64[31:0];

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = lanes[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return res;
  endfunction

  // Sign/zero extension of the assembled load bytes.
  always_comb begin
    w_ld_ext = 32'h0;
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
      3'b001:  w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
      3'b010:  w_ld_ext = w_ld_raw;
      3'b100:  w_ld_ext = {24'h0, w_ld_raw[7:0]};
      3'b101:  w_ld_ext = {16'h0, w_ld_raw[15:0]};
      default: w_ld_ext = 32'h0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (!w_req_legal)          w_next = S_RESP;
          else if (!req_we)          w_next = S_LD0;
          else if (w_req_sw_aligned) w_next = S_WR0;
          else                       w_next = S_RMW_RD0;
        end
      end
      S_LD0:     w_next = w_span ? S_LD1 : S_RESP;
      S_LD1:     w_next = S_RESP;
      S_RMW_RD0: w_next = S_WR0;
      S_WR0:     w_next = w_span ? S_RMW_RD1 : S_RESP;
      S_RMW_RD1: w_next = S_WR1;
      S_WR1:     w_next = S_RESP;
      S_RESP:    w_next = resp_ready ? S_IDLE : S_RESP;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch at accept, and word capture in the read states.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_word0  <= '0;
      r_off    <= 2'b00;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      r_buf0   <= 32'h0;
      r_buf1   <= 32'h0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_word0  <= req_addr[ADDR_W+1:2];
        r_off    <= req_addr[1:0];
        r_wdata  <= req_wdata;
        r_err    <= !w_req_legal;
      end
      if (r_state == S_LD0 || r_state == S_RMW_RD0) r_buf0 <= mem_rd;
      if (r_state == S_LD1 || r_state == S_RMW_RD1) r_buf1 <= mem_rd;
    end
  end

  // Outputs decoded from state; memory writes are blocked while in reset.
  always_comb begin
    req_ready  = (r_state == S_IDLE) && RST;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wd     = 32'h0;
    case (r_state)
      S_LD0, S_RMW_RD0: mem_addr = {{(32-ADDR_W){1'b0}}, r_word0};
      S_LD1, S_RMW_RD1: mem_addr = {{(32-ADDR_W){1'b0}}, w_word1};
      S_WR0: begin
        mem_we   = 1'b1;
        mem_addr = {{(32-ADDR_W){1'b0}}, r_word0};
        mem_wd   = f_merge(r_buf0, w_sdata64[31:0], w_mask8[3:0]);
      end
      S_WR1: begin
        mem_we   = 1'b1;
        mem_addr = {{(32-ADDR_W){1'b0}}, w_word1};
        mem_wd   = f_merge(r_buf1, w_sdata64[63:32], w_mask8[7:4]);
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (!r_we && !r_err) ? w_ld_ext : 32'h0;
      end
      default: ;
    endcase
    if (!RST) mem_we = 1'b0;
  end

  assign dbg_state = r_state;

endmodule
